uart_rx_fifo: RTL and testbench

//  Configurable UART receiver: 2-flop input synchroniser, start-bit validation,
//  N data bits (LSB first), optional odd/even parity and 1-2 stop bits.

---
 rtl/uart_rx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity and 1-2 stop bits, feeding a
// show-ahead FIFO of {parity_err, frame_err, data} words read over valid/ready.
module uart_rx_fifo #(
    parameter int unsigned CLOCK_RATE   = 25175000,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned COUNTER_SIZE = 12,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 rx,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_BITS-1:0]                 out_data,
    output logic                                 out_frame_err,
    output logic                                 out_parity_err,
    output logic                                 overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int unsigned BIT  = CLOCK_RATE / BAUD_RATE - 1;
    localparam int unsigned HALF = CLOCK_RATE / (2 * BAUD_RATE) - 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam int unsigned EntW = DATA_BITS + 2;

    localparam logic [COUNTER_SIZE-1:0] CntBit   = COUNTER_SIZE'(BIT);
    localparam logic [COUNTER_SIZE-1:0] CntHalf  = COUNTER_SIZE'(HALF);
    localparam logic [IdxW-1:0]         LastIdx  = IdxW'(DATA_BITS - 1);
    localparam logic [CntW-1:0]         CntOne   = CntW'(1);
    localparam logic [CntW-1:0]         CntFull  = CntW'(FIFO_DEPTH);

    if ($clog2(BIT + 1) > COUNTER_SIZE || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_rx_fifo: illegal parameter combination");
    end

    // Input synchroniser plus one extra stage for falling-edge detection
    logic rx_meta, rs, rs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
            rs_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
            rs_prev <= rs;
        end
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                  state_q;
    logic [COUNTER_SIZE-1:0] cnt_q;
    logic [IdxW-1:0]         idx_q;
    logic [DATA_BITS-1:0]    data_q;
    logic                    perr_q, ferr_q, stop_idx_q;

    logic            bit_tick, stop_last, push;
    logic [EntW-1:0] push_word;

    assign bit_tick  = (cnt_q == CntBit);
    assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;
    assign push      = (state_q == StStop) && bit_tick && stop_last;
    // The final stop sample is folded in combinationally so the word is pushed on that edge
    assign push_word = {perr_q, ferr_q | ~rs, data_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rs && rs_prev) state_q <= StStart;
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q <= '0;
                        if (rs) begin
                            state_q <= StIdle;
                        end else begin
                            state_q    <= StData;
                            idx_q      <= '0;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                            stop_idx_q <= 1'b0;
                        end
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        cnt_q  <= '0;
                        data_q <= {rs, data_q[DATA_BITS-1:1]};
                        idx_q  <= idx_q + 1'b1;
                        if (idx_q == LastIdx) state_q <= (PARITY != 0) ? StParity : StStop;
                    end
                end
                StParity: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        perr_q  <= ((^data_q) ^ rs) != (PARITY == 1);
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (bit_tick) begin
                        cnt_q      <= '0;
                        ferr_q     <= ferr_q | ~rs;
                        stop_idx_q <= 1'b1;
                        if (stop_last) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO with a registered head entry so the outputs hold while empty
    logic [EntW-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
    logic [CntW-1:0] count_q;
    logic [EntW-1:0] head_q, head_d;
    logic            pop, full, accept;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count_q == CntFull);
    assign accept    = push & (~full | pop);
    assign rd_next   = rd_ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= push_word;
    end

    always_comb begin
        head_d = head_q;
        if (pop && count_q > CntOne) begin
            head_d = mem[rd_next];
        end else if (accept && (count_q == '0 || pop)) begin
            head_d = push_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            overrun  <= 1'b0;
        end else begin
            head_q  <= head_d;
            overrun <= push & full & ~pop;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_next;
            if (accept && !pop)      count_q <= count_q + 1'b1;
            else if (!accept && pop) count_q <= count_q - 1'b1;
        end
    end

    assign {out_parity_err, out_frame_err, out_data} = head_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: four receiver configurations (8N1, 8E1, 8O1, 7N2) on a 16-clock bit period.
module tb_uart_rx_fifo;

    localparam int unsigned CR = 160;
    localparam int unsigned BR = 10;
    localparam int unsigned CS = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rx = '1;
    logic [3:0] rdy = '0;
    logic [3:0] vld, ferr, perr, ovr;
    logic [2:0] cnt [4];
    logic [7:0] dat [3];
    logic [6:0] dat_d;

    int total = 0;
    int bad = 0;
    int ovr_seen = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .COUNTER_SIZE(CS), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst_n(rst_n), .rx(rx[0]), .out_valid(vld[0]), .out_ready(rdy[0]),
        .out_data(dat[0]), .out_frame_err(ferr[0]), .out_parity_err(perr[0]),
        .overrun(ovr[0]), .fifo_count(cnt[0]));

    uart_rx_fifo #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .COUNTER_SIZE(CS), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_e (
        .clk(clk), .rst_n(rst_n), .rx(rx[1]), .out_valid(vld[1]), .out_ready(rdy[1]),
        .out_data(dat[1]), .out_frame_err(ferr[1]), .out_parity_err(perr[1]),
        .overrun(ovr[1]), .fifo_count(cnt[1]));

    uart_rx_fifo #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .COUNTER_SIZE(CS), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_o (
        .clk(clk), .rst_n(rst_n), .rx(rx[2]), .out_valid(vld[2]), .out_ready(rdy[2]),
        .out_data(dat[2]), .out_frame_err(ferr[2]), .out_parity_err(perr[2]),
        .overrun(ovr[2]), .fifo_count(cnt[2]));

    uart_rx_fifo #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .COUNTER_SIZE(CS), .DATA_BITS(7),
                   .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_d (
        .clk(clk), .rst_n(rst_n), .rx(rx[3]), .out_valid(vld[3]), .out_ready(rdy[3]),
        .out_data(dat_d), .out_frame_err(ferr[3]), .out_parity_err(perr[3]),
        .overrun(ovr[3]), .fifo_count(cnt[3]));

    always @(negedge clk) if (ovr[0]) ovr_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] head(input int idx);
        if (idx == 3) return {2'b00, dat_d};
        return {1'b0, dat[idx]};
    endfunction

    // One frame, 16 clocks per bit; pbit<0 means no parity bit. Optionally pulses ready
    // at cycle pop_cyc and stops driving after max_cyc cycles.
    task automatic send(input int idx, input logic [8:0] d, input int nd, input int pbit,
                        input int nstop, input logic sv, input int pop_cyc, input int max_cyc);
        logic [15:0] b;
        int n;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < nd; i++) b[1 + i] = d[i];
        n = 1 + nd;
        if (pbit >= 0) begin
            b[n] = pbit[0];
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            b[n] = sv;
            n++;
        end
        for (int c = 0; c < n * 16 && (max_cyc < 0 || c < max_cyc); c++) begin
            rx[idx] = b[c / 16];
            if (pop_cyc >= 0 && c == pop_cyc) rdy[idx] = 1'b1;
            else if (pop_cyc >= 0 && c == pop_cyc + 1) rdy[idx] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pop_check(input int idx, input int d, input int fe, input int pe,
                             input string tag);
        check({tag, ".valid"}, 32'(vld[idx]), 32'd1);
        check({tag, ".data"}, 32'(head(idx)), 32'(d));
        check({tag, ".ferr"}, 32'(ferr[idx]), 32'(fe));
        check({tag, ".perr"}, 32'(perr[idx]), 32'(pe));
        rdy[idx] = 1'b1;
        @(negedge clk);
        rdy[idx] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst.valid", 32'(vld[0]), 32'd0);
        check("rst.data", 32'(dat[0]), 32'd0);
        check("rst.flags", 32'({ferr[0], perr[0]}), 32'd0);
        check("rst.overrun", 32'(ovr[0]), 32'd0);
        check("rst.count", 32'(cnt[0]), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: visible exactly one cycle after the stop sample
        send(0, 9'hA5, 8, -1, 1, 1'b1, -1, 154);
        check("t1.pre_valid", 32'(vld[0]), 32'd0);
        @(negedge clk);
        check("t1.count", 32'(cnt[0]), 32'd1);
        pop_check(0, 'hA5, 0, 0, "t1");
        check("t1.empty", 32'(vld[0]), 32'd0);
        check("t1.count0", 32'(cnt[0]), 32'd0);
        repeat (10) @(negedge clk);

        // Short glitch, then a real frame
        rx[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx[0] = 1'b1;
        repeat (30) @(negedge clk);
        check("t2.glitch_count", 32'(cnt[0]), 32'd0);
        send(0, 9'h3C, 8, -1, 1, 1'b1, -1, -1);
        pop_check(0, 'h3C, 0, 0, "t2");

        // Low stop bit, line then held low
        send(0, 9'h55, 8, -1, 1, 1'b0, -1, -1);
        repeat (200) @(negedge clk);
        check("t3.held_count", 32'(cnt[0]), 32'd1);
        pop_check(0, 'h55, 1, 0, "t3");
        rx[0] = 1'b1;
        repeat (16) @(negedge clk);
        send(0, 9'h00, 8, -1, 1, 1'b0, -1, -1);
        check("t3.break_count", 32'(cnt[0]), 32'd1);
        pop_check(0, 'h00, 1, 0, "t3b");
        rx[0] = 1'b1;
        repeat (20) @(negedge clk);

        // Parity
        send(1, 9'h03, 8, 0, 1, 1'b1, -1, -1);
        pop_check(1, 'h03, 0, 0, "t4.even_ok");
        send(1, 9'h03, 8, 1, 1, 1'b1, -1, -1);
        pop_check(1, 'h03, 0, 1, "t4.even_bad");
        send(2, 9'h03, 8, 1, 1, 1'b1, -1, -1);
        pop_check(2, 'h03, 0, 0, "t4.odd_ok");
        send(2, 9'h03, 8, 0, 1, 1'b1, -1, -1);
        pop_check(2, 'h03, 0, 1, "t4.odd_bad");

        // Overrun: five back-to-back frames into a depth-4 FIFO
        for (int k = 1; k <= 5; k++) send(0, 9'(k), 8, -1, 1, 1'b1, -1, -1);
        check("t5.overrun_pulses", 32'(ovr_seen), 32'd1);
        check("t5.count", 32'(cnt[0]), 32'd4);
        for (int k = 1; k <= 4; k++) pop_check(0, k, 0, 0, "t5.read");
        check("t5.drained", 32'(cnt[0]), 32'd0);
        for (int k = 1; k <= 4; k++) send(0, 9'(k), 8, -1, 1, 1'b1, -1, -1);
        send(0, 9'h05, 8, -1, 1, 1'b1, 154, -1);
        check("t5b.overrun_pulses", 32'(ovr_seen), 32'd1);
        check("t5b.count", 32'(cnt[0]), 32'd4);
        for (int k = 2; k <= 5; k++) pop_check(0, k, 0, 0, "t5b.read");

        // Reset mid-frame with words queued, then a 7N2 frame
        send(3, 9'h11, 7, -1, 2, 1'b1, -1, -1);
        send(3, 9'h22, 7, -1, 2, 1'b1, -1, -1);
        check("t6.queued", 32'(cnt[3]), 32'd2);
        send(3, 9'h55, 7, -1, 2, 1'b1, -1, 70);
        rst_n = 1'b0;
        #1;
        check("t6.rst_valid", 32'(vld[3]), 32'd0);
        check("t6.rst_count", 32'(cnt[3]), 32'd0);
        rx[3] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(3, 9'h7E, 7, -1, 2, 1'b1, -1, -1);
        check("t6.count", 32'(cnt[3]), 32'd1);
        pop_check(3, 'h7E, 0, 0, "t6");
        check("t6.empty", 32'(cnt[3]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
